// File: rtl/silly_seq_pkg.sv
// -----------------------------------------------------------------------------
// silly_seq_pkg
// Shared definitions for the silly_seq step sequencer:
//   - state_t       : playback FSM state (IDLE / HOLD)
//   - DEF_NUM_STEPS : default number of step-table entries
//   - DEF_MASK_W    : default mask word width
//   - DEF_LEN_W     : default per-step hold-length width
// -----------------------------------------------------------------------------
package silly_seq_pkg;

    localparam int DEF_NUM_STEPS = 4;
    localparam int DEF_MASK_W    = 8;
    localparam int DEF_LEN_W     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/silly_seq_table.sv
// -----------------------------------------------------------------------------
// silly_seq_table
// Step table for silly_seq: NUM_STEPS entries of {mask, len}.
// Synchronous write, combinational read, every entry cleared by reset.
//
// Ports:
//   clk        in   clock (posedge)
//   i_reset    in   synchronous active-high reset, clears all entries
//   i_we       in   write strobe (already qualified by the caller)
//   i_wr_addr  in   entry index to write
//   i_wr_mask  in   mask value to store
//   i_wr_len   in   hold length to store
//   i_rd_addr  in   entry index to read
//   o_rd_mask  out  mask of entry i_rd_addr
//   o_rd_len   out  hold length of entry i_rd_addr
// -----------------------------------------------------------------------------
module silly_seq_table
    import silly_seq_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int MASK_W    = DEF_MASK_W,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_we,
    input  logic [$clog2(NUM_STEPS)-1:0] i_wr_addr,
    input  logic [MASK_W-1:0]            i_wr_mask,
    input  logic [LEN_W-1:0]             i_wr_len,
    input  logic [$clog2(NUM_STEPS)-1:0] i_rd_addr,
    output logic [MASK_W-1:0]            o_rd_mask,
    output logic [LEN_W-1:0]             o_rd_len
);

    logic [MASK_W-1:0] r_mask [NUM_STEPS];
    logic [LEN_W-1:0]  r_len  [NUM_STEPS];

    always_ff @(posedge clk) begin
        if (i_reset) begin
            // NOTE: this is a small flop array, not a RAM macro, so clearing
            // every entry on reset is cheap and the cleared table is visible
            // behaviour (a post-reset start plays all-zero masks).
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_mask[i] <= '0;
                r_len[i]  <= '0;
            end
        end else if (i_we) begin
            r_mask[i_wr_addr] <= i_wr_mask;
            r_len[i_wr_addr]  <= i_wr_len;
        end
    end

    assign o_rd_mask = r_mask[i_rd_addr];
    assign o_rd_len  = r_len[i_rd_addr];

endmodule

// File: rtl/silly_seq.sv
// -----------------------------------------------------------------------------
// silly_seq
// Step sequencer: plays a programmable table of {mask, len} entries, holding
// each mask on mask_out for len+1 cycles. mask_out feeds an AND-gating
// datapath, so it is forced to 0 whenever the sequencer is not playing.
//
// Build option:
//   SILLY_SEQ_LOOP_EN  defined   -> last step wraps to step 0, done never pulses
//                      undefined -> last step returns to IDLE and pulses done
//
// Ports:
//   clk       in   clock (posedge)
//   reset     in   synchronous active-high reset (also clears the table)
//   start     in   begin playback (IDLE only, ignored while playing)
//   stop      in   abort playback (wins over start and step advance)
//   wr_en     in   table write strobe (accepted in IDLE, rejected in HOLD)
//   wr_addr   in   table entry index
//   wr_mask   in   mask value for the entry
//   wr_len    in   hold length for the entry
//   mask_out  out  registered mask of the active step, 0 when idle
//   busy      out  high while playing
//   step_idx  out  index of the active step
//   done      out  one-cycle pulse on normal completion
//   wr_err    out  one-cycle pulse, the cycle after a rejected write
// -----------------------------------------------------------------------------
module silly_seq
    import silly_seq_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int MASK_W    = DEF_MASK_W,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
    input  logic [MASK_W-1:0]            wr_mask,
    input  logic [LEN_W-1:0]             wr_len,
    output logic [MASK_W-1:0]            mask_out,
    output logic                         busy,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         done,
    output logic                         wr_err
);

    localparam int                ADDR_W   = $clog2(NUM_STEPS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_STEPS - 1);

    state_t             r_state;
    logic [MASK_W-1:0]  r_mask;
    logic [ADDR_W-1:0]  r_step_idx;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_done;
    logic               r_wr_err;

    logic               w_tbl_we;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [MASK_W-1:0]  w_rd_mask;
    logic [LEN_W-1:0]   w_rd_len;

    // Writes are only accepted while idle; in HOLD they are flagged instead.
    assign w_tbl_we = wr_en && (r_state == IDLE);

    // One read port is enough: IDLE only ever needs entry 0 (for start), HOLD
    // only ever needs the next entry. idx+1 wraps from the last entry to 0
    // because NUM_STEPS is a power of two, which is exactly the loop target.
    assign w_rd_addr = (r_state == HOLD) ? (r_step_idx + ADDR_W'(1)) : '0;

    silly_seq_table #(
        .NUM_STEPS (NUM_STEPS),
        .MASK_W    (MASK_W),
        .LEN_W     (LEN_W)
    ) u_table (
        .clk       (clk),
        .i_reset   (reset),
        .i_we      (w_tbl_we),
        .i_wr_addr (wr_addr),
        .i_wr_mask (wr_mask),
        .i_wr_len  (wr_len),
        .i_rd_addr (w_rd_addr),
        .o_rd_mask (w_rd_mask),
        .o_rd_len  (w_rd_len)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_step_idx <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all of them update from the
            // same pre-edge values; blocking = would make later statements in
            // this block see already-updated state.
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        r_state    <= HOLD;
                        r_step_idx <= '0;
                        r_mask     <= w_rd_mask;
                        r_cnt      <= w_rd_len;
                    end
                end

                HOLD: begin
                    r_wr_err <= wr_en;
                    if (stop) begin
                        r_state    <= IDLE;
                        r_mask     <= '0;
                        r_step_idx <= '0;
                        r_cnt      <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_step_idx != LAST_IDX) begin
                        r_step_idx <= w_rd_addr;
                        r_mask     <= w_rd_mask;
                        r_cnt      <= w_rd_len;
                    end else begin
`ifdef SILLY_SEQ_LOOP_EN
                        // w_rd_addr has wrapped to 0 here, so entry 0 is loaded.
                        r_step_idx <= '0;
                        r_mask     <= w_rd_mask;
                        r_cnt      <= w_rd_len;
`else
                        r_state    <= IDLE;
                        r_mask     <= '0;
                        r_step_idx <= '0;
                        r_cnt      <= '0;
                        r_done     <= 1'b1;
`endif
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_mask  <= '0;
                end
            endcase
        end
    end

    assign mask_out = r_mask;
    assign busy     = (r_state == HOLD);
    assign step_idx = r_step_idx;
    assign done     = r_done;
    assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_silly_seq.sv
module tb_silly_seq;

    localparam int N  = 4;
    localparam int MW = 8;
    localparam int LW = 8;
    localparam int AW = 2;

`ifdef SILLY_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_mask;
    logic [LW-1:0] wr_len;
    logic [MW-1:0] mask_out;
    logic          busy;
    logic [AW-1:0] step_idx;
    logic          done;
    logic          wr_err;

    int checks = 0;
    int errors = 0;

    // Reference copy of the step table, updated only by accepted writes.
    logic [MW-1:0] m_mask [N];
    logic [LW-1:0] m_len  [N];

    silly_seq #(
        .NUM_STEPS (N),
        .MASK_W    (MW),
        .LEN_W     (LW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_len   (wr_len),
        .mask_out (mask_out),
        .busy     (busy),
        .step_idx (step_idx),
        .done     (done),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " mask"}, 32'(mask_out), 32'(0));
        check({tag, " busy"}, 32'(busy), 32'(0));
        check({tag, " idx"},  32'(step_idx), 32'(0));
        check({tag, " done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic write_entry(input int a, input logic [MW-1:0] m, input logic [LW-1:0] l);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_mask = m;
        wr_len  = l;
        step();
        wr_en = 1'b0;
        m_mask[a] = m;
        m_len[a]  = l;
    endtask

    task automatic load_ref_table();
        write_entry(0, 8'h01, 8'd0);
        write_entry(1, 8'h02, 8'd1);
        write_entry(2, 8'h04, 8'd2);
        write_entry(3, 8'h08, 8'd3);
    endtask

    // Plays the table once (twice plus the wrap cycle when looping) and checks
    // every cycle against the expected mask stream built from the table.
    // rand_ctl: random start pulses and rejected writes during playback.
    // wr_at   : cycle index at which a write to entry 1 is forced (-1 = none).
    task automatic play(input string tag, input bit rand_ctl, input int wr_at);
        logic [MW-1:0] q_mask[$];
        int            q_idx[$];
        int            reps;
        int            n;
        bit            last;
        logic          pw;

        reps = LOOP ? 2 : 1;
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < N; i++)
                for (int c = 0; c <= int'(m_len[i]); c++) begin
                    q_mask.push_back(m_mask[i]);
                    q_idx.push_back(i);
                end
        if (LOOP) begin
            q_mask.push_back(m_mask[0]);
            q_idx.push_back(0);
        end
        n = q_mask.size();

        start = 1'b1;
        stop  = 1'b0;
        step();
        start = 1'b0;
        pw    = 1'b0;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s mask k=%0d", tag, k), 32'(mask_out), 32'(q_mask[k]));
            check($sformatf("%s idx k=%0d", tag, k),  32'(step_idx), 32'(q_idx[k]));
            check($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(1));
            check($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(0));
            check($sformatf("%s wr_err k=%0d", tag, k), 32'(wr_err), 32'(pw));
            last  = (k == n - 1);
            start = (rand_ctl && !last) ? 1'($urandom_range(0, 1)) : 1'b0;
            wr_en = (rand_ctl && !last) ? 1'($urandom_range(0, 1)) : 1'b0;
            wr_addr = AW'($urandom_range(0, N - 1));
            wr_mask = MW'($urandom);
            wr_len  = LW'($urandom);
            if (k == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = AW'(1);
                wr_mask = 8'hAA;
                wr_len  = 8'd7;
            end
            pw = wr_en;
            if (LOOP && last) stop = 1'b1;
            step();
        end
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        check_idle({tag, " end"}, LOOP ? 1'b0 : 1'b1);
        check({tag, " end wr_err"}, 32'(wr_err), 32'(pw));
        step();
        check({tag, " after done"}, 32'(done), 32'(0));
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_mask = '0;
        wr_len  = '0;
        for (int i = 0; i < N; i++) begin
            m_mask[i] = '0;
            m_len[i]  = '0;
        end
        step();
        step();
        check_idle("reset", 1'b0);
        check("reset wr_err", 32'(wr_err), 32'(0));
        reset = 1'b0;
        step();

        // Reference table: 01 x1, 02 x2, 04 x3, 08 x4, then done (or wrap).
        load_ref_table();
        play("ref", 1'b0, -1);

        // Random tables with random start/write noise during playback.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++)
                write_entry(i, MW'($urandom), LW'($urandom_range(0, 4)));
            play($sformatf("rand%0d", t), 1'b1, -1);
        end

        // Hold-length boundaries: len 0 (1 cycle) and len max (256 cycles).
        write_entry(0, 8'h5A, 8'd0);
        write_entry(1, 8'hC3, 8'd1);
        write_entry(2, 8'hFF, 8'd255);
        write_entry(3, 8'h81, 8'd0);
        play("len_max", 1'b0, -1);

        // Write to entry 1 during HOLD is rejected; replay shows entry 1 intact.
        load_ref_table();
        play("wr_hold", 1'b0, 1);
        play("replay", 1'b0, -1);

        // Stop on the 2nd cycle of step 2.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        check("stop pre mask", 32'(mask_out), 32'(8'h04));
        check("stop pre idx", 32'(step_idx), 32'(2));
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("stop", 1'b0);
        step();
        check_idle("stop+1", 1'b0);

        // start and stop together in IDLE: nothing happens.
        start = 1'b1;
        stop  = 1'b1;
        step();
        check_idle("start_stop", 1'b0);
        step();
        check_idle("start_stop+1", 1'b0);
        start = 1'b0;
        stop  = 1'b0;

        // Reset during step 1 clears outputs and table.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("pre reset idx", 32'(step_idx), 32'(1));
        check("pre reset mask", 32'(mask_out), 32'(8'h02));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("mid reset", 1'b0);
        check("mid reset wr_err", 32'(wr_err), 32'(0));
        for (int i = 0; i < N; i++) begin
            m_mask[i] = '0;
            m_len[i]  = '0;
        end
        play("cleared", 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/silly_seq.md
SILLY_SEQ -- requirements
Module: silly_seq

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 4, meaning the number of step-table entries; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have parameter MASK_W, default 8, meaning the width of the mask word driven to the AND-gating datapath.
REQ-003 SHALL have parameter LEN_W, default 8, meaning the width of the per-step hold-length field.
REQ-004 SHALL have port clk  input  1  clock; all logic is posedge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  begin sequence playback.
REQ-007 SHALL have port stop  input  1  abort playback.
REQ-008 SHALL have port wr_en  input  1  step-table write strobe.
REQ-009 SHALL have port wr_addr  input  log2(NUM_STEPS)  step-table entry index.
REQ-010 SHALL have port wr_mask  input  MASK_W  mask value for the entry.
REQ-011 SHALL have port wr_len  input  LEN_W  hold length for the entry.
REQ-012 SHALL have port mask_out  output  MASK_W  registered mask, fed to the gating datapath.
REQ-013 SHALL have port busy  output  1  high while playing.
REQ-014 SHALL have port step_idx  output  log2(NUM_STEPS)  index of the active step.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal sequence completion.
REQ-016 SHALL have port wr_err  output  1  one-cycle pulse when a write is rejected.

Function
REQ-017 SHALL implement FSM states IDLE and HOLD; busy = (state==HOLD).
REQ-018 In IDLE, a write SHALL store {wr_mask, wr_len} into entry wr_addr at the clock edge; no other entry changes.
REQ-019 In HOLD, writes SHALL be discarded and wr_err SHALL pulse high for one cycle, registered on the following cycle.
REQ-020 IDLE with start=1 and stop=0 at edge t SHALL produce, at t+1: state HOLD, step_idx=0, mask_out=entry0.mask, and hold counter=entry0.len.
REQ-021 Each step SHALL present its mask for exactly len+1 cycles; len=0 gives 1 cycle and len=2^LEN_W-1 gives 2^LEN_W cycles.
REQ-022 In HOLD with counter>0, the counter SHALL decrement by 1 per cycle.
REQ-023 In HOLD with counter=0 and step_idx<NUM_STEPS-1, the block SHALL advance to step_idx+1 at the next edge, loading that entry's mask and len, with no gap cycle.
REQ-024 In HOLD with counter=0 and step_idx=NUM_STEPS-1, the behaviour SHALL be as given in REQ-031/REQ-032.
REQ-025 stop=1 in HOLD SHALL, at the next edge, force state IDLE, mask_out=0 and step_idx=0, and SHALL NOT pulse done.
REQ-026 stop SHALL take priority over start and over step advance when asserted in the same cycle.
REQ-027 start in HOLD SHALL be ignored; playback does not restart.
REQ-028 In IDLE, mask_out SHALL be 0.

Reset
REQ-029 reset SHALL override all other inputs: state IDLE, mask_out=0, step_idx=0, counter=0, done=0, wr_err=0.
REQ-030 reset SHALL clear all step-table entries to mask=0 and len=0; a reset asserted mid-playback takes effect at the next edge.

Configuration
REQ-031 With SILLY_SEQ_LOOP_EN defined, completing the last step SHALL wrap to step 0 (entry0 loaded, step_idx=0) with no gap cycle, repeating until stop or reset; done SHALL never pulse.
REQ-032 Without SILLY_SEQ_LOOP_EN, completing the last step SHALL, at the next edge, go to IDLE with mask_out=0, step_idx=0 and done=1 for one cycle; a subsequent start replays from step 0.

Structure
REQ-033 Package silly_seq_pkg SHALL hold the FSM state enum and the default NUM_STEPS, MASK_W and LEN_W constants.
REQ-034 The step table SHALL be a separate sub-module, silly_seq_table: synchronous write, combinational read, and clear on reset.

Verification
REQ-035 Write entries 0..3 = {01,0},{02,1},{04,2},{08,3} (hex masks), then pulse start -> mask_out sequence 01 x1, 02 x2, 04 x3, 08 x4 cycles; then (no LOOP_EN) mask_out=00 and done=1 for 1 cycle.
REQ-036 Same table with SILLY_SEQ_LOOP_EN defined -> after 08 x4, mask_out=01 on the next cycle; pattern period is 10 cycles; done stays 0.
REQ-037 Pulse stop on the 2nd cycle of step 2 -> next cycle mask_out=00, busy=0, step_idx=0, done=0.
REQ-038 Assert wr_en with addr 1 during HOLD -> wr_err=1 for one cycle; entry 1 unchanged on replay.
REQ-039 Assert start and stop together in IDLE -> state remains IDLE and mask_out=00.
REQ-040 Assert reset during step 1 -> next cycle all outputs 0; start then plays all entries as 00 for 1 cycle each (table cleared).
